// File: rtl/pipeline_regs_pkg.sv
// Shared latch payload types, controller state encoding and bubble constants
// for the 5-stage pipeline latches.
package pipeline_regs_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } FD_t;

  typedef struct packed {
    logic        regwr;
    logic        memwr;
    logic        dcuREN;
    logic        dcuWEN;
    logic        halt;
    logic [4:0]  rt;
    logic [4:0]  wsel;
    logic [31:0] data;
  } DE_t;

  typedef struct packed {
    logic        regwr;
    logic        memwr;
    logic        dcuREN;
    logic        dcuWEN;
    logic        halt;
    logic [4:0]  wsel;
    logic [31:0] addr;
    logic [31:0] data;
  } EM_t;

  typedef struct packed {
    logic        regwr;
    logic        halt;
    logic [4:0]  wsel;
    logic [31:0] data;
  } MW_t;

  // A bubble is an all-zero payload: no register write, no memory access, no halt.
  localparam FD_t FD_BUBBLE = '0;
  localparam DE_t DE_BUBBLE = '0;
  localparam EM_t EM_BUBBLE = '0;
  localparam MW_t MW_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: the load sitting in DE writes a register that the
// instruction in FD reads, so FD must wait one cycle.
module hazard_detect (
  input  logic       de_dcu_ren_i,
  input  logic [4:0] de_rt_i,
  input  logic [4:0] dec_rs_i,
  input  logic [4:0] dec_rt_i,
  output logic       load_use_o
);

  // $0 is hardwired to zero, so a load into it never creates a dependency.
  assign load_use_o = de_dcu_ren_i & (de_rt_i != 5'd0) &
                      ((de_rt_i == dec_rs_i) | (de_rt_i == dec_rt_i));

endmodule

// File: rtl/pipeline_latch_ctrl.sv
// Owns the FD/DE/EM/MW latches and decides each cycle whether every latch
// advances, holds or takes a bubble; also tracks halt and stall cycles.
module pipeline_latch_ctrl
  import pipeline_regs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             ex_flush,
  input  logic [4:0]       dec_rs,
  input  logic [4:0]       dec_rt,
  input  FD_t              FD_in,
  input  DE_t              DE_in,
  input  EM_t              EM_in,
  input  MW_t              MW_in,
  output FD_t              FD_out,
  output DE_t              DE_out,
  output EM_t              EM_out,
  output MW_t              MW_out,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_state_t      state_q, state_d;
  FD_t              fd_q, fd_d;
  DE_t              de_q, de_d;
  EM_t              em_q, em_d;
  MW_t              mw_q, mw_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             mem_busy;
  logic             load_use;
  logic             stall_evt;
  logic             pc_en_c;

  assign mem_busy = (em_q.dcuREN | em_q.dcuWEN) & ~dhit;

  hazard_detect u_hazard_detect (
    .de_dcu_ren_i (de_q.dcuREN),
    .de_rt_i      (de_q.rt),
    .dec_rs_i     (dec_rs),
    .dec_rt_i     (dec_rt),
    .load_use_o   (load_use)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      fd_q    <= FD_BUBBLE;
      de_q    <= DE_BUBBLE;
      em_q    <= EM_BUBBLE;
      mw_q    <= MW_BUBBLE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      fd_q    <= fd_d;
      de_q    <= de_d;
      em_q    <= em_d;
      mw_q    <= mw_d;
      stall_q <= stall_d;
    end
  end

  // Halt in MW outranks a pending D-cache miss: the access is simply abandoned.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mw_q.halt)    state_d = HALTED;
        else if (mem_busy) state_d = DWAIT;
      end
      DWAIT: begin
        if (mw_q.halt)    state_d = HALTED;
        else if (dhit)    state_d = RUN;
      end
      HALTED:             state_d = HALTED;
      default:            state_d = RUN;
    endcase
  end

  // Priority order: memory stall, flush, load-use, I-cache miss, advance.
  always_comb begin
    fd_d      = fd_q;
    de_d      = de_q;
    em_d      = em_q;
    mw_d      = mw_q;
    pc_en_c   = 1'b0;
    stall_evt = 1'b0;
    if (state_q != HALTED) begin
      if (mem_busy) begin
        mw_d      = MW_BUBBLE;
        stall_evt = 1'b1;
      end else if (ex_flush) begin
        fd_d      = FD_BUBBLE;
        de_d      = DE_BUBBLE;
        em_d      = EM_in;
        mw_d      = MW_in;
        pc_en_c   = 1'b1;
        stall_evt = 1'b1;
      end else if (load_use) begin
        de_d      = DE_BUBBLE;
        em_d      = EM_in;
        mw_d      = MW_in;
        stall_evt = 1'b1;
      end else if (!ihit) begin
        fd_d      = FD_BUBBLE;
        de_d      = DE_in;
        em_d      = EM_in;
        mw_d      = MW_in;
        stall_evt = 1'b1;
      end else begin
        fd_d      = FD_in;
        de_d      = DE_in;
        em_d      = EM_in;
        mw_d      = MW_in;
        pc_en_c   = 1'b1;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_evt && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
  end

  // PC must not move while reset is being applied.
  assign pc_en     = pc_en_c & ~RST;
  assign halted    = (state_q == HALTED);
  assign stall_cnt = stall_q;
  assign FD_out    = fd_q;
  assign DE_out    = de_q;
  assign EM_out    = em_q;
  assign MW_out    = mw_q;

endmodule

// File: tb/tb_pipeline_latch_ctrl.sv
// Directed bench for pipeline_latch_ctrl: advance, load-use, D-cache wait,
// flush, halt freeze and reset recovery with hand-computed expectations.
module tb_pipeline_latch_ctrl;
  import pipeline_regs_pkg::*;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic        dhit;
  logic        ex_flush;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  FD_t         FD_in, FD_out;
  DE_t         DE_in, DE_out;
  EM_t         EM_in, EM_out;
  MW_t         MW_in, MW_out;
  logic        pc_en;
  logic        halted;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  DE_t deLw, deX, deY;
  EM_t emE1, emEL, emE3, emE4;
  MW_t mwM1, mwM2, mwM3, mwM4, mwMH;

  pipeline_latch_ctrl #(.CNT_W(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ihit      (ihit),
    .dhit      (dhit),
    .ex_flush  (ex_flush),
    .dec_rs    (dec_rs),
    .dec_rt    (dec_rt),
    .FD_in     (FD_in),
    .DE_in     (DE_in),
    .EM_in     (EM_in),
    .MW_in     (MW_in),
    .FD_out    (FD_out),
    .DE_out    (DE_out),
    .EM_out    (EM_out),
    .MW_out    (MW_out),
    .pc_en     (pc_en),
    .halted    (halted),
    .stall_cnt (stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic rstV, input logic ihitV, input logic dhitV,
                               input logic flushV, input logic [4:0] rsV, input logic [4:0] rtV);
    RST      = rstV;
    ihit     = ihitV;
    dhit     = dhitV;
    ex_flush = flushV;
    dec_rs   = rsV;
    dec_rt   = rtV;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Sample one time unit after the rising edge so registered outputs are settled.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    deLw = '0; deLw.dcuREN = 1'b1; deLw.regwr = 1'b1; deLw.rt = 5'd2; deLw.wsel = 5'd2;
    deX  = '0; deX.regwr = 1'b1; deX.wsel = 5'd9; deX.data = 32'h0000_0099;
    deY  = '0; deY.regwr = 1'b1; deY.wsel = 5'd6; deY.data = 32'h0000_0066;
    emE1 = '0; emE1.regwr = 1'b1; emE1.wsel = 5'd3; emE1.addr = 32'h100; emE1.data = 32'hAA;
    emEL = '0; emEL.dcuREN = 1'b1; emEL.regwr = 1'b1; emEL.wsel = 5'd7; emEL.addr = 32'h200;
    emE3 = '0; emE3.regwr = 1'b1; emE3.wsel = 5'd5; emE3.data = 32'h33;
    emE4 = '0; emE4.regwr = 1'b1; emE4.wsel = 5'd8; emE4.data = 32'h44;
    mwM1 = '0; mwM1.regwr = 1'b1; mwM1.wsel = 5'd4; mwM1.data = 32'h11;
    mwM2 = '0; mwM2.regwr = 1'b1; mwM2.wsel = 5'd4; mwM2.data = 32'h22;
    mwM3 = '0; mwM3.regwr = 1'b1; mwM3.wsel = 5'd10; mwM3.data = 32'h55;
    mwM4 = '0; mwM4.regwr = 1'b1; mwM4.wsel = 5'd11; mwM4.data = 32'h77;
    mwMH = '0; mwMH.halt = 1'b1;

    FD_in = '0; DE_in = '0; EM_in = '0; MW_in = '0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    #1;
    tick();
    tick();
    checkOutput("rst_fd", 128'(FD_out), 128'(0));
    checkOutput("rst_de", 128'(DE_out), 128'(0));
    checkOutput("rst_em", 128'(EM_out), 128'(0));
    checkOutput("rst_mw", 128'(MW_out), 128'(0));
    checkOutput("rst_pc_en", 128'(pc_en), 128'(0));
    checkOutput("rst_halted", 128'(halted), 128'(0));
    checkOutput("rst_stall", 128'(stall_cnt), 128'(0));

    // Steady flow: each FD_in value shows up in FD_out one edge later.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    for (int i = 1; i <= 5; i++) begin
      FD_in.instr = 32'(i);
      FD_in.pc4   = 32'(4 * i);
      #1;
      checkOutput("flow_pc_en", 128'(pc_en), 128'(1));
      tick();
      checkOutput("flow_fd", 128'(FD_out.instr), 128'(i));
    end
    checkOutput("flow_stall", 128'(stall_cnt), 128'(0));

    // Load into $2 enters DE while instruction 6 enters FD.
    FD_in = '0; FD_in.instr = 32'd6;
    DE_in = deLw;
    tick();
    checkOutput("lw_in_de", 128'(DE_out), 128'(deLw));
    // Consumer reads $2; I-cache miss at the same time must not bubble FD.
    FD_in.instr = 32'd7;
    DE_in = deX;
    EM_in = emE1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 5'd0);
    #1;
    checkOutput("lu_pc_en", 128'(pc_en), 128'(0));
    tick();
    checkOutput("lu_fd_hold", 128'(FD_out.instr), 128'(6));
    checkOutput("lu_de_bubble", 128'(DE_out), 128'(0));
    checkOutput("lu_em_adv", 128'(EM_out), 128'(emE1));
    checkOutput("lu_stall", 128'(stall_cnt), 128'(1));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 5'd0);
    #1;
    checkOutput("lu_clear_pc_en", 128'(pc_en), 128'(1));
    tick();
    checkOutput("lu_proceed_fd", 128'(FD_out.instr), 128'(7));
    checkOutput("lu_proceed_de", 128'(DE_out), 128'(deX));
    checkOutput("lu_stall_kept", 128'(stall_cnt), 128'(1));

    // D-cache miss: load in EM waits three cycles for dhit.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    EM_in = emEL;
    MW_in = mwM1;
    tick();
    checkOutput("dw_em_load", 128'(EM_out), 128'(emEL));
    FD_in.instr = 32'd8;
    DE_in = deY;
    EM_in = emE3;
    MW_in = mwM2;
    #1;
    checkOutput("dw_pc_en", 128'(pc_en), 128'(0));
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("dw_mw_bubble", 128'(MW_out), 128'(0));
      checkOutput("dw_em_hold", 128'(EM_out), 128'(emEL));
      checkOutput("dw_fd_hold", 128'(FD_out.instr), 128'(7));
      checkOutput("dw_de_hold", 128'(DE_out), 128'(deX));
    end
    checkOutput("dw_stall", 128'(stall_cnt), 128'(4));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
    #1;
    checkOutput("dw_hit_pc_en", 128'(pc_en), 128'(1));
    tick();
    checkOutput("dw_hit_mw", 128'(MW_out), 128'(mwM2));
    checkOutput("dw_hit_em", 128'(EM_out), 128'(emE3));
    checkOutput("dw_hit_fd", 128'(FD_out.instr), 128'(8));
    checkOutput("dw_hit_stall", 128'(stall_cnt), 128'(4));

    // Flush with I-cache miss: FD/DE bubble, EM/MW advance, PC redirects.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
    EM_in = emE4;
    MW_in = mwM3;
    #1;
    checkOutput("fl_pc_en", 128'(pc_en), 128'(1));
    tick();
    checkOutput("fl_fd", 128'(FD_out), 128'(0));
    checkOutput("fl_de", 128'(DE_out), 128'(0));
    checkOutput("fl_em", 128'(EM_out), 128'(emE4));
    checkOutput("fl_mw", 128'(MW_out), 128'(mwM3));
    checkOutput("fl_stall", 128'(stall_cnt), 128'(5));

    // Halt reaches MW, then the block halts after one more (advancing) edge.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    FD_in.instr = 32'd9;
    MW_in = mwMH;
    tick();
    checkOutput("ht_mw_halt", 128'(MW_out), 128'(mwMH));
    checkOutput("ht_not_yet", 128'(halted), 128'(0));
    FD_in.instr = 32'd10;
    MW_in = mwM4;
    tick();
    checkOutput("ht_halted", 128'(halted), 128'(1));
    checkOutput("ht_fd_last", 128'(FD_out.instr), 128'(10));
    FD_in.instr = 32'd11;
    MW_in = mwM1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("ht_fd_frozen", 128'(FD_out.instr), 128'(10));
      checkOutput("ht_mw_frozen", 128'(MW_out), 128'(mwM4));
      checkOutput("ht_stall_frozen", 128'(stall_cnt), 128'(5));
      checkOutput("ht_pc_en", 128'(pc_en), 128'(0));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    checkOutput("ht_rst_halted", 128'(halted), 128'(0));
    checkOutput("ht_rst_fd", 128'(FD_out), 128'(0));
    checkOutput("ht_rst_de", 128'(DE_out), 128'(0));
    checkOutput("ht_rst_em", 128'(EM_out), 128'(0));
    checkOutput("ht_rst_mw", 128'(MW_out), 128'(0));
    checkOutput("ht_rst_stall", 128'(stall_cnt), 128'(0));

    // Reset in DWAIT with dhit high: the retire is dropped and MW clears.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    FD_in.instr = 32'd12;
    DE_in = '0;
    EM_in = emEL;
    MW_in = mwM1;
    tick();
    checkOutput("rd_em_load", 128'(EM_out), 128'(emEL));
    tick();
    checkOutput("rd_mw_bubble", 128'(MW_out), 128'(0));
    checkOutput("rd_stall", 128'(stall_cnt), 128'(1));
    MW_in = mwM2;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    checkOutput("rd_mw_zero", 128'(MW_out), 128'(0));
    checkOutput("rd_em_zero", 128'(EM_out), 128'(0));
    checkOutput("rd_fd_zero", 128'(FD_out), 128'(0));
    checkOutput("rd_stall_zero", 128'(stall_cnt), 128'(0));
    checkOutput("rd_halted", 128'(halted), 128'(0));
    EM_in = '0;
    FD_in.instr = 32'd13;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    #1;
    checkOutput("rd_run_pc_en", 128'(pc_en), 128'(1));
    tick();
    checkOutput("rd_run_fd", 128'(FD_out.instr), 128'(13));
    checkOutput("rd_run_stall", 128'(stall_cnt), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
